gpu_copy_cpuvram_burst: RTL and testbench
=========================================

GPU_COPY_CPUVRAM_BURST -- requirements
Module: gpu_copy_cpuvram_burst

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning pixels delivered per FIFO pop; legal values 1, 2, 4.
REQ-002 SHALL have ports listed below; one clock; reset is synchronous and active-high.
REQ-003 i_clk  in  1  clock, all state on rising edge.
REQ-004 i_rst  in  1  synchronous active-high reset.
REQ-005 i_start  in  1  one-cycle pulse, latch rectangle and mode, begin copy; ignored unless IDLE.
REQ-006 i_abort  in  1  terminate copy; no further commands.
REQ-007 i_x0[9:0], i_y0[8:0], i_sizeW[10:0], i_sizeH[9:0]  in  rectangle origin and size.
REQ-008 i_checkMask, i_forceMask  in  1 each  mask-test and mask-set modes.
REQ-009 i_fifoValid  in  1; i_fifoData  in  16*LANES  pixels, lane 0 first; o_fifoRead  out  1  pop.
REQ-010 o_stencilReadSig  out  1; o_stencilReadAdr  out  15; i_stencilReadValue  in  16  (1-cycle latency).
REQ-011 o_stencilWriteSig  out  1; o_stencilWriteAdr  out  15; o_stencilWriteMask16, o_stencilWriteValue16  out  16.
REQ-012 o_command, o_write, o_adr[14:0], o_subadr[2:0], o_commandSize[1:0], o_writeMask[15:0], o_dataOut[255:0]  out; i_busy  in  1.
REQ-013 o_active  out  1  high while not IDLE; o_done  out  1  one-cycle completion pulse.

Function
REQ-014 VRAM SHALL be 1024x512 16bpp; block = 16 pixels of one row; block address = {y[8:0], x[9:4]}; pixel lane = x[3:0].
REQ-015 Effective width SHALL be ((sizeW-1) & 0x3FF)+1, effective height ((sizeH-1) & 0x1FF)+1 (size 0 -> 1024/512).
REQ-016 FSM states: IDLE, STENCIL, PIXEL, FLUSH, DONE.
REQ-017 IDLE->STENCIL on i_start; STENCIL issues o_stencilReadSig for current block, next cycle captures value, ->PIXEL.
REQ-018 PIXEL consumes at most one pixel per cycle from an internal LANES-wide buffer; buffer refilled by o_fifoRead only when buffer empty and i_fifoValid; o_fifoRead = i_fifoValid & buffer-empty & PIXEL state.
REQ-019 Pixels SHALL stream row-major; lanes of one pop may straddle row ends; x and y wrap modulo 1024 / 512.
REQ-020 Pixel written iff !(i_checkMask & stencil bit); written data = {pixel[15] | i_forceMask, pixel[14:0]} placed at bits [16*lane +: 16].
REQ-021 PIXEL->FLUSH when pixel at lane 15 consumed, at row end, at X wrap (1023->0), or after last pixel.
REQ-022 FLUSH: o_command=1, o_write=1, o_commandSize=1 (32 byte), o_subadr=0, o_writeMask = written-pixel bits; held stable until cycle with i_busy=0 (accept).
REQ-023 Stencil write SHALL pulse in accept cycle: same address, mask=o_writeMask, value bit = written pixel bit 15 after force.
REQ-024 Block with zero written pixels SHALL skip command and stencil write (FLUSH exits in one cycle).
REQ-025 After accept: more pixels -> STENCIL for next block; else -> DONE.
REQ-026 DONE: o_done=1 one cycle, leftover buffered lanes discarded, ->IDLE.
REQ-027 i_abort in any non-IDLE state -> IDLE next cycle, buffer cleared, no o_done; if in FLUSH, an accepted command in that same cycle completes, otherwise no command.
REQ-028 Total pixel counter SHALL be 20 bits (max 524288); stencil-read to capture is exactly 1 cycle.

Reset
REQ-029 On i_rst: state IDLE, buffer empty, all outputs 0 (o_command, o_fifoRead, stencil sigs, o_done, o_active, o_dataOut, masks).
REQ-030 Reset mid-copy SHALL drop the copy without issuing further commands.

Verification
REQ-031 LANES=2, x0=0,y0=0,W=16,H=1, mask off -> one command adr 0, writeMask 0xFFFF, 8 pops, o_done.
REQ-032 x0=1020,y0=511,W=8,H=2 -> commands adr {511,63} mask 0xF000, {511,0} mask 0x000F, then y wraps to 0: {0,63}, {0,0}.
REQ-033 W=3,H=1,LANES=2 -> 2 pops, last lane discarded, writeMask 0x0007, o_done.
REQ-034 i_checkMask=1, stencil value 0x00FF for block -> writeMask 0xFF00; all-ones stencil -> no command.
REQ-035 i_busy held high 5 cycles during FLUSH -> command signals stable, accepted once, stencil write once.
REQ-036 i_abort in PIXEL state -> IDLE next cycle, no command, no o_done; sizeW=0 -> 1024-pixel rows (64 commands per row).

Source files
------------

// File: rtl/gpu_copy_cpuvram_burst.sv
// gpu_copy_cpuvram_burst: streams CPU FIFO pixels into a VRAM rectangle as masked 16-pixel block writes with stencil test/update
module gpu_copy_cpuvram_burst #(
  parameter int LANES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [9:0]            i_x0,
  input  logic [8:0]            i_y0,
  input  logic [10:0]           i_sizeW,
  input  logic [9:0]            i_sizeH,
  input  logic                  i_checkMask,
  input  logic                  i_forceMask,
  input  logic                  i_fifoValid,
  input  logic [16*LANES-1:0]   i_fifoData,
  output logic                  o_fifoRead,
  output logic                  o_stencilReadSig,
  output logic [14:0]           o_stencilReadAdr,
  input  logic [15:0]           i_stencilReadValue,
  output logic                  o_stencilWriteSig,
  output logic [14:0]           o_stencilWriteAdr,
  output logic [15:0]           o_stencilWriteMask16,
  output logic [15:0]           o_stencilWriteValue16,
  output logic                  o_command,
  output logic                  o_write,
  output logic [14:0]           o_adr,
  output logic [2:0]            o_subadr,
  output logic [1:0]            o_commandSize,
  output logic [15:0]           o_writeMask,
  output logic [255:0]          o_dataOut,
  input  logic                  i_busy,
  output logic                  o_active,
  output logic                  o_done
);
  localparam logic [2:0] IDLE = 3'd0, STENCIL = 3'd1, PIXEL = 3'd2, FLUSH = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic st_wait, check_q, force_q;
  logic [9:0] x0_q, cur_x;
  logic [8:0] cur_y;
  logic [10:0] width_q, col_left, eff_w;
  logic [9:0] eff_h;
  logic [19:0] remaining;
  logic [14:0] blk_adr;
  logic [15:0] stencil_q, mask_q, st_val, pix;
  logic [255:0] data_q;
  logic [16*LANES-1:0] buf_q;
  logic [2:0] buf_cnt;
  logic [3:0] lane;
  logic consume, wr, row_end, blk_end, has_px, accept;
  assign eff_w = ((i_sizeW - 11'd1) & 11'h3FF) + 11'd1;
  assign eff_h = ((i_sizeH - 10'd1) & 10'h1FF) + 10'd1;
  assign lane = cur_x[3:0];
  assign pix = buf_q[15:0];
  assign consume = state == PIXEL && buf_cnt != 3'd0;
  assign wr = !(check_q && stencil_q[lane]);
  assign row_end = col_left == 11'd1;
  assign blk_end = &lane || row_end || remaining == 20'd1;
  assign has_px = |mask_q;
  assign accept = state == FLUSH && (!has_px || !i_busy);
  assign o_fifoRead = state == PIXEL && buf_cnt == 3'd0 && i_fifoValid;
  assign o_stencilReadSig = state == STENCIL && !st_wait;
  assign o_stencilReadAdr = o_stencilReadSig ? {cur_y, cur_x[9:4]} : '0;
  assign o_command = state == FLUSH && has_px;
  assign o_write = o_command;
  assign o_adr = o_command ? blk_adr : '0;
  assign o_subadr = '0;
  assign o_commandSize = {1'b0, o_command};
  assign o_writeMask = o_command ? mask_q : '0;
  assign o_dataOut = o_command ? data_q : '0;
  assign o_stencilWriteSig = o_command && !i_busy;
  assign o_stencilWriteAdr = o_stencilWriteSig ? blk_adr : '0;
  assign o_stencilWriteMask16 = o_stencilWriteSig ? mask_q : '0;
  assign o_stencilWriteValue16 = o_stencilWriteSig ? st_val : '0;
  assign o_active = state != IDLE;
  assign o_done = state == DONE;
  always_comb begin
    st_val = '0;
    for (int i = 0; i < 16; i++) st_val[i] = data_q[16*i+15];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      st_wait <= 1'b0;
      buf_cnt <= '0;
      mask_q <= '0;
      data_q <= '0;
    end else if (state != IDLE && i_abort) begin
      state <= IDLE;
      buf_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          x0_q <= i_x0;
          cur_x <= i_x0;
          cur_y <= i_y0;
          width_q <= eff_w;
          col_left <= eff_w;
          remaining <= 20'(eff_w) * 20'(eff_h);
          check_q <= i_checkMask;
          force_q <= i_forceMask;
          st_wait <= 1'b0;
          buf_cnt <= '0;
          state <= STENCIL;
        end
        STENCIL: begin
          st_wait <= !st_wait;
          if (st_wait) begin
            stencil_q <= i_stencilReadValue;
            mask_q <= '0;
            data_q <= '0;
            state <= PIXEL;
          end else blk_adr <= {cur_y, cur_x[9:4]};
        end
        PIXEL: if (o_fifoRead) begin
          buf_q <= i_fifoData;
          buf_cnt <= 3'(LANES);
        end else if (consume) begin
          buf_q <= buf_q >> 16;
          buf_cnt <= buf_cnt - 3'd1;
          if (wr) begin
            mask_q[lane] <= 1'b1;
            data_q[16*lane +: 16] <= {pix[15] | force_q, pix[14:0]};
          end
          remaining <= remaining - 20'd1;
          col_left <= row_end ? width_q : col_left - 11'd1;
          cur_x <= row_end ? x0_q : cur_x + 10'd1;
          cur_y <= row_end ? cur_y + 9'd1 : cur_y;
          if (blk_end) state <= FLUSH;
        end
        FLUSH: if (accept) state <= remaining == 20'd0 ? DONE : STENCIL;
        DONE: begin
          buf_cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_copy_cpuvram_burst.sv
// tb_gpu_copy_cpuvram_burst: randomized copies checked against a pixel-level rectangle/stencil reference model
module tb_gpu_copy_cpuvram_burst;
  localparam int L = 2;
  logic i_clk = 1'b0;
  logic i_rst, i_start, i_abort, i_checkMask, i_forceMask, i_fifoValid, i_busy;
  logic [9:0] i_x0;
  logic [8:0] i_y0;
  logic [10:0] i_sizeW;
  logic [9:0] i_sizeH;
  logic [16*L-1:0] i_fifoData;
  logic [15:0] i_stencilReadValue;
  logic o_fifoRead, o_stencilReadSig, o_stencilWriteSig, o_command, o_write, o_active, o_done;
  logic [14:0] o_stencilReadAdr, o_stencilWriteAdr, o_adr;
  logic [15:0] o_stencilWriteMask16, o_stencilWriteValue16, o_writeMask;
  logic [2:0] o_subadr;
  logic [1:0] o_commandSize;
  logic [255:0] o_dataOut;
  always #5 i_clk = ~i_clk;
  gpu_copy_cpuvram_burst #(.LANES(L)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_x0(i_x0), .i_y0(i_y0), .i_sizeW(i_sizeW), .i_sizeH(i_sizeH),
    .i_checkMask(i_checkMask), .i_forceMask(i_forceMask),
    .i_fifoValid(i_fifoValid), .i_fifoData(i_fifoData), .o_fifoRead(o_fifoRead),
    .o_stencilReadSig(o_stencilReadSig), .o_stencilReadAdr(o_stencilReadAdr),
    .i_stencilReadValue(i_stencilReadValue),
    .o_stencilWriteSig(o_stencilWriteSig), .o_stencilWriteAdr(o_stencilWriteAdr),
    .o_stencilWriteMask16(o_stencilWriteMask16), .o_stencilWriteValue16(o_stencilWriteValue16),
    .o_command(o_command), .o_write(o_write), .o_adr(o_adr), .o_subadr(o_subadr),
    .o_commandSize(o_commandSize), .o_writeMask(o_writeMask), .o_dataOut(o_dataOut),
    .i_busy(i_busy), .o_active(o_active), .o_done(o_done)
  );
  typedef struct packed {
    logic [14:0] adr;
    logic [15:0] mask;
    logic [255:0] data;
  } cmd_t;
  cmd_t expq[$];
  cmd_t held;
  logic [15:0] pix[$];
  logic [15:0] stencil_mem [32768];
  logic [15:0] ref_sten [32768];
  int errors = 0, checks = 0;
  int pop_idx, pops, cmd_cnt, sw_cnt, done_cnt, hold_cnt, busy_mode, g_adr;
  logic start_req, abort_req, rst_req, pend, held_valid;
  logic [14:0] pend_adr, last_adr;
  logic [15:0] last_mask, g_mask;
  logic [255:0] g_data;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic close_grp();
    cmd_t c;
    logic [15:0] v;
    if (g_adr < 0 || g_mask == 16'd0) return;
    for (int i = 0; i < 16; i++) v[i] = g_data[16*i+15];
    c.adr = 15'(g_adr);
    c.mask = g_mask;
    c.data = g_data;
    expq.push_back(c);
    ref_sten[g_adr] = (ref_sten[g_adr] & ~g_mask) | (v & g_mask);
  endtask
  task automatic build(input int x0, input int y0, input int sw, input int sh, input int chk, input int frc, output int n);
    int ew, eh, x, y, adr, ln;
    logic [15:0] s, p;
    ew = ((sw - 1) & 1023) + 1;
    eh = ((sh - 1) & 511) + 1;
    n = ew * eh;
    pix.delete();
    expq.delete();
    g_adr = -1;
    s = '0;
    for (int k = 0; k < n; k++) begin
      p = 16'($urandom);
      pix.push_back(p);
      x = (x0 + k % ew) % 1024;
      y = (y0 + k / ew) % 512;
      adr = y * 64 + x / 16;
      ln = x % 16;
      if (adr != g_adr) begin
        close_grp();
        g_adr = adr;
        g_mask = '0;
        g_data = '0;
        s = ref_sten[adr];
      end
      if (!(chk != 0 && s[ln])) begin
        g_mask[ln] = 1'b1;
        g_data[ln*16 +: 16] = {p[15] | (frc != 0), p[14:0]};
      end
    end
    close_grp();
  endtask
  task automatic step();
    cmd_t e;
    logic [15:0] v;
    @(posedge i_clk);
    #1;
    i_rst = rst_req;
    rst_req = 1'b0;
    i_start = start_req;
    start_req = 1'b0;
    i_abort = abort_req;
    abort_req = 1'b0;
    i_fifoValid = $urandom_range(0, 3) != 0;
    for (int l = 0; l < L; l++)
      i_fifoData[16*l +: 16] = (pop_idx * L + l < pix.size()) ? pix[pop_idx*L+l] : 16'($urandom);
    i_busy = busy_mode == 1 ? $urandom_range(0, 2) == 0 : busy_mode == 2 ? (o_command && hold_cnt < 5) : 1'b0;
    if (busy_mode == 2 && i_busy) hold_cnt++;
    i_stencilReadValue = pend ? stencil_mem[pend_adr] : 16'($urandom);
    pend = 1'b0;
    @(negedge i_clk);
    if (o_fifoRead) begin
      pop_idx++;
      pops++;
    end
    if (o_stencilReadSig) begin
      pend = 1'b1;
      pend_adr = o_stencilReadAdr;
    end
    if (o_done) done_cnt++;
    check("swr_only_on_accept", o_stencilWriteSig, o_command && !i_busy);
    if (held_valid) begin
      check("hold_cmd", o_command, 1);
      check("hold_adr", o_adr, held.adr);
      check("hold_mask", o_writeMask, held.mask);
      check("hold_data", o_dataOut, held.data);
      held_valid = 1'b0;
    end
    if (o_command && i_busy) begin
      held_valid = 1'b1;
      held.adr = o_adr;
      held.mask = o_writeMask;
      held.data = o_dataOut;
    end else if (o_command) begin
      cmd_cnt++;
      last_mask = o_writeMask;
      last_adr = o_adr;
      check("cmd_fmt", {o_write, o_commandSize, o_subadr}, {1'b1, 2'd1, 3'd0});
      check("cmd_expected", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        for (int i = 0; i < 16; i++) v[i] = e.data[16*i+15];
        check("cmd_adr", o_adr, e.adr);
        check("cmd_mask", o_writeMask, e.mask);
        check("cmd_data", o_dataOut, e.data);
        check("swr_adr", o_stencilWriteAdr, e.adr);
        check("swr_mask", o_stencilWriteMask16, e.mask);
        check("swr_val", o_stencilWriteValue16, v & e.mask);
      end
    end
    if (o_stencilWriteSig) begin
      sw_cnt++;
      for (int i = 0; i < 16; i++)
        if (o_stencilWriteMask16[i]) stencil_mem[o_stencilWriteAdr][i] = o_stencilWriteValue16[i];
    end
  endtask
  task automatic clear_counts(input int bm);
    pop_idx = 0;
    pops = 0;
    cmd_cnt = 0;
    sw_cnt = 0;
    done_cnt = 0;
    hold_cnt = 0;
    busy_mode = bm;
  endtask
  task automatic set_rect(input int x0, input int y0, input int sw, input int sh, input int chk, input int frc);
    i_x0 = 10'(x0);
    i_y0 = 9'(y0);
    i_sizeW = 11'(sw);
    i_sizeH = 10'(sh);
    i_checkMask = chk != 0;
    i_forceMask = frc != 0;
  endtask
  task automatic run_copy(input int x0, input int y0, input int sw, input int sh, input int chk, input int frc, input int bm, input string tag);
    int n, ec, cyc;
    build(x0, y0, sw, sh, chk, frc, n);
    ec = expq.size();
    clear_counts(bm);
    set_rect(x0, y0, sw, sh, chk, frc);
    start_req = 1'b1;
    cyc = 0;
    while (done_cnt == 0 && cyc < n * 30 + 200) begin
      step();
      cyc++;
    end
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_cmds"}, cmd_cnt, ec);
    check({tag, "_swr"}, sw_cnt, ec);
    check({tag, "_pops"}, pops, (n + L - 1) / L);
    step();
    check({tag, "_idle"}, {o_active, o_done}, 2'b00);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {o_command, o_write, o_fifoRead, o_stencilReadSig, o_stencilWriteSig, o_done, o_active}, 7'd0);
    check({tag, "_data"}, o_dataOut, 0);
    check({tag, "_mask"}, {o_writeMask, o_stencilWriteMask16}, 0);
  endtask
  task automatic run_abort(input bit use_rst, input string tag);
    int cyc;
    pix.delete();
    expq.delete();
    for (int k = 0; k < 64; k++) pix.push_back(16'($urandom));
    clear_counts(0);
    set_rect(0, 7, 16, 2, 0, 0);
    start_req = 1'b1;
    cyc = 0;
    while (pops == 0 && cyc < 50) begin
      step();
      cyc++;
    end
    check({tag, "_pop_seen"}, pops, 1);
    if (use_rst) rst_req = 1'b1;
    else abort_req = 1'b1;
    step();
    step();
    if (use_rst) check_zero(tag);
    else check({tag, "_idle"}, o_active, 0);
    repeat (30) step();
    check({tag, "_no_cmd"}, cmd_cnt, 0);
    check({tag, "_no_swr"}, sw_cnt, 0);
    check({tag, "_no_done"}, done_cnt, 0);
  endtask
  initial begin
    int x0, y0, sw, sh;
    {i_rst, i_start, i_abort, i_checkMask, i_forceMask, i_fifoValid, i_busy} = '0;
    {i_x0, i_y0, i_sizeW, i_sizeH, i_fifoData, i_stencilReadValue} = '0;
    {start_req, abort_req, pend, held_valid} = '0;
    pend_adr = '0;
    last_adr = '0;
    last_mask = '0;
    clear_counts(0);
    for (int a = 0; a < 32768; a++) begin
      stencil_mem[a] = 16'($urandom);
      ref_sten[a] = stencil_mem[a];
    end
    rst_req = 1'b1;
    step();
    check_zero("reset");
    step();
    run_copy(0, 0, 16, 1, 0, 0, 0, "r031");
    check("r031_adr", last_adr, 0);
    check("r031_mask", last_mask, 16'hFFFF);
    run_copy(1020, 511, 8, 2, 0, 0, 1, "r032");
    check("r032_last_adr", last_adr, {9'd0, 6'd0});
    run_copy(0, 3, 3, 1, 0, 0, 0, "r033");
    check("r033_mask", last_mask, 16'h0007);
    stencil_mem[{9'd5, 6'd0}] = 16'h00FF;
    ref_sten[{9'd5, 6'd0}] = 16'h00FF;
    run_copy(0, 5, 16, 1, 1, 0, 0, "r034a");
    check("r034a_mask", last_mask, 16'hFF00);
    stencil_mem[{9'd6, 6'd0}] = 16'hFFFF;
    ref_sten[{9'd6, 6'd0}] = 16'hFFFF;
    run_copy(0, 6, 16, 1, 1, 1, 0, "r034b");
    check("r034b_none", cmd_cnt, 0);
    run_copy(32, 9, 16, 1, 0, 1, 2, "r035");
    check("r035_once", {cmd_cnt[7:0], sw_cnt[7:0]}, {8'd1, 8'd1});
    run_abort(1'b0, "abort");
    run_abort(1'b1, "midrst");
    run_copy(0, 100, 0, 1, 0, 0, 1, "r036w");
    check("r036w_64", cmd_cnt, 64);
    run_copy(1015, 0, 1, 0, 1, 0, 1, "h512");
    for (int r = 0; r < 12; r++) begin
      x0 = r % 3 == 0 ? $urandom_range(1000, 1023) : $urandom_range(0, 1023);
      y0 = r % 4 == 0 ? $urandom_range(508, 511) : $urandom_range(0, 511);
      sw = $urandom_range(1, 40);
      sh = $urandom_range(1, 4);
      run_copy(x0, y0, sw, sh, $urandom_range(0, 1), $urandom_range(0, 1), 1, "rnd");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
